// File: rtl/pmem_arbiter.sv
// Physical-memory port arbiter: IFU/LSU share one port, one transaction in flight.
// Optional performance counters are enabled with `define PMEM_ARB_PERF_EN.
module pmem_arbiter #(
    parameter int MEM_LATENCY  = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ifu_req_valid,
    output logic        ifu_req_ready,
    input  logic [63:0] ifu_req_addr,
    output logic        ifu_resp_valid,
    output logic [31:0] ifu_resp_inst,
    input  logic        lsu_req_valid,
    output logic        lsu_req_ready,
    input  logic [63:0] lsu_req_addr,
    input  logic        lsu_req_wen,
    input  logic [63:0] lsu_req_wdata,
    input  logic [7:0]  lsu_req_wmask,
    output logic        lsu_resp_valid,
    output logic [63:0] lsu_resp_rdata,
`ifdef PMEM_ARB_PERF_EN
    output logic [31:0] perf_ifu_grants,
    output logic [31:0] perf_lsu_grants,
    output logic [31:0] perf_conflicts,
`endif
    output logic        mem_en,
    output logic [63:0] mem_addr,
    output logic        mem_wen,
    output logic [63:0] mem_wdata,
    output logic [7:0]  mem_wmask,
    input  logic [63:0] mem_rdata
);
    localparam int LAT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam int STV_W = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    state_e       state_q, state_d;
    logic         owner_lsu_q, owner_lsu_d;
    logic [63:0]  addr_q, addr_d;
    logic         wen_q, wen_d;
    logic [63:0]  wdata_q, wdata_d;
    logic [7:0]   wmask_q, wmask_d;
    logic [LAT_W-1:0] lat_q, lat_d;
    logic [STV_W-1:0] starve_q, starve_d;
    logic [31:0]  inst_q, inst_d;
    logic [63:0]  lrdata_q, lrdata_d;
    logic         mem_en_q, mem_en_d;
    logic         mem_wen_q, mem_wen_d;
    logic         ifu_rv_q, ifu_rv_d;
    logic         lsu_rv_q, lsu_rv_d;

    logic idle_s, ifu_force_s, grant_ifu_s, grant_lsu_s, wen_new_s;

    // IFU is forced through once LSU has won STARVE_LIMIT times in a row against it
    assign idle_s      = (state_q == ST_IDLE);
    assign ifu_force_s = (starve_q == STV_W'(STARVE_LIMIT));
    assign grant_ifu_s = idle_s & ifu_req_valid & (~lsu_req_valid | ifu_force_s);
    assign grant_lsu_s = idle_s & lsu_req_valid & ~grant_ifu_s;
    assign wen_new_s   = grant_lsu_s & lsu_req_wen;

    assign ifu_req_ready  = rst_n & grant_ifu_s;
    assign lsu_req_ready  = rst_n & grant_lsu_s;
    assign ifu_resp_valid = ifu_rv_q;
    assign lsu_resp_valid = lsu_rv_q;
    assign ifu_resp_inst  = inst_q;
    assign lsu_resp_rdata = lrdata_q;
    assign mem_en         = mem_en_q;
    assign mem_wen        = mem_wen_q;
    assign mem_addr       = addr_q;
    assign mem_wdata      = wdata_q;
    assign mem_wmask      = wmask_q;

    // Next-state, request latch, response capture and registered strobe decode
    always_comb begin
        state_d     = state_q;
        owner_lsu_d = owner_lsu_q;
        addr_d      = addr_q;
        wen_d       = wen_q;
        wdata_d     = wdata_q;
        wmask_d     = wmask_q;
        lat_d       = lat_q;
        starve_d    = starve_q;
        inst_d      = inst_q;
        lrdata_d    = lrdata_q;
        mem_en_d    = 1'b0;
        mem_wen_d   = 1'b0;
        ifu_rv_d    = 1'b0;
        lsu_rv_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (grant_ifu_s || grant_lsu_s) begin
                    state_d     = ST_WAIT;
                    owner_lsu_d = grant_lsu_s;
                    addr_d      = grant_lsu_s ? lsu_req_addr : ifu_req_addr;
                    wen_d       = wen_new_s;
                    wdata_d     = grant_lsu_s ? lsu_req_wdata : 64'd0;
                    wmask_d     = grant_lsu_s ? lsu_req_wmask : 8'd0;
                    lat_d       = LAT_W'(MEM_LATENCY - 1);
                    mem_en_d    = ~wen_new_s;
                    mem_wen_d   = wen_new_s;
                    if (grant_ifu_s) begin
                        starve_d = {STV_W{1'b0}};
                    end else if (ifu_req_valid && !ifu_force_s) begin
                        starve_d = starve_q + STV_W'(1);
                    end else begin
                        starve_d = starve_q;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (lat_q == {LAT_W{1'b0}}) begin
                    state_d  = ST_RESP;
                    ifu_rv_d = ~owner_lsu_q;
                    lsu_rv_d = owner_lsu_q;
                    if (owner_lsu_q) begin
                        lrdata_d = wen_q ? 64'd0 : mem_rdata;
                    end else begin
                        inst_d = addr_q[2] ? mem_rdata[63:32] : mem_rdata[31:0];
                    end
                end else begin
                    lat_d    = lat_q - LAT_W'(1);
                    mem_en_d = ~wen_q;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            owner_lsu_q <= 1'b0;
            addr_q      <= 64'd0;
            wen_q       <= 1'b0;
            wdata_q     <= 64'd0;
            wmask_q     <= 8'd0;
            lat_q       <= {LAT_W{1'b0}};
            starve_q    <= {STV_W{1'b0}};
            inst_q      <= 32'd0;
            lrdata_q    <= 64'd0;
            mem_en_q    <= 1'b0;
            mem_wen_q   <= 1'b0;
            ifu_rv_q    <= 1'b0;
            lsu_rv_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_lsu_q <= owner_lsu_d;
            addr_q      <= addr_d;
            wen_q       <= wen_d;
            wdata_q     <= wdata_d;
            wmask_q     <= wmask_d;
            lat_q       <= lat_d;
            starve_q    <= starve_d;
            inst_q      <= inst_d;
            lrdata_q    <= lrdata_d;
            mem_en_q    <= mem_en_d;
            mem_wen_q   <= mem_wen_d;
            ifu_rv_q    <= ifu_rv_d;
            lsu_rv_q    <= lsu_rv_d;
        end
    end

`ifdef PMEM_ARB_PERF_EN
    logic [31:0] perf_ifu_q, perf_lsu_q, perf_conf_q;

    assign perf_ifu_grants = perf_ifu_q;
    assign perf_lsu_grants = perf_lsu_q;
    assign perf_conflicts  = perf_conf_q;

    // Free-running wrap-around grant and conflict counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_ifu_q  <= 32'd0;
            perf_lsu_q  <= 32'd0;
            perf_conf_q <= 32'd0;
        end else begin
            perf_ifu_q  <= perf_ifu_q + {31'd0, grant_ifu_s};
            perf_lsu_q  <= perf_lsu_q + {31'd0, grant_lsu_s};
            perf_conf_q <= perf_conf_q + {31'd0, idle_s & ifu_req_valid & lsu_req_valid};
        end
    end
`endif

endmodule

// File: tb/tb_pmem_arbiter.sv
// Directed bench for pmem_arbiter: one instance at MEM_LATENCY=1 (a), one at 3 (b),
// sharing request inputs; each gets its own combinational memory model.
module tb_pmem_arbiter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        ifu_req_valid;
    logic [63:0] ifu_req_addr;
    logic        lsu_req_valid;
    logic [63:0] lsu_req_addr;
    logic        lsu_req_wen;
    logic [63:0] lsu_req_wdata;
    logic [7:0]  lsu_req_wmask;
    logic [63:0] rd_val;

    logic        ifu_rdy_a, ifu_rv_a, lsu_rdy_a, lsu_rv_a, men_a, mwen_a;
    logic [31:0] inst_a;
    logic [63:0] lrd_a, maddr_a, mwdata_a, mrdata_a;
    logic [7:0]  mwmask_a;
    logic        ifu_rdy_b, ifu_rv_b, lsu_rdy_b, lsu_rv_b, men_b, mwen_b;
    logic [31:0] inst_b;
    logic [63:0] lrd_b, maddr_b, mwdata_b, mrdata_b;
    logic [7:0]  mwmask_b;
`ifdef PMEM_ARB_PERF_EN
    logic [31:0] pig_a, plg_a, pc_a, pig_b, plg_b, pc_b;
`endif

    int n_checks = 0;
    int n_errors = 0;

    assign mrdata_a = men_a ? rd_val : 64'd0;
    assign mrdata_b = men_b ? rd_val : 64'd0;

    always #5 clk = ~clk;

    pmem_arbiter #(.MEM_LATENCY(1), .STARVE_LIMIT(4)) u_a (
        .clk(clk), .rst_n(rst_n),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_rdy_a), .ifu_req_addr(ifu_req_addr),
        .ifu_resp_valid(ifu_rv_a), .ifu_resp_inst(inst_a),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_rdy_a), .lsu_req_addr(lsu_req_addr),
        .lsu_req_wen(lsu_req_wen), .lsu_req_wdata(lsu_req_wdata), .lsu_req_wmask(lsu_req_wmask),
        .lsu_resp_valid(lsu_rv_a), .lsu_resp_rdata(lrd_a),
`ifdef PMEM_ARB_PERF_EN
        .perf_ifu_grants(pig_a), .perf_lsu_grants(plg_a), .perf_conflicts(pc_a),
`endif
        .mem_en(men_a), .mem_addr(maddr_a), .mem_wen(mwen_a), .mem_wdata(mwdata_a),
        .mem_wmask(mwmask_a), .mem_rdata(mrdata_a)
    );

    pmem_arbiter #(.MEM_LATENCY(3), .STARVE_LIMIT(4)) u_b (
        .clk(clk), .rst_n(rst_n),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_rdy_b), .ifu_req_addr(ifu_req_addr),
        .ifu_resp_valid(ifu_rv_b), .ifu_resp_inst(inst_b),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_rdy_b), .lsu_req_addr(lsu_req_addr),
        .lsu_req_wen(lsu_req_wen), .lsu_req_wdata(lsu_req_wdata), .lsu_req_wmask(lsu_req_wmask),
        .lsu_resp_valid(lsu_rv_b), .lsu_resp_rdata(lrd_b),
`ifdef PMEM_ARB_PERF_EN
        .perf_ifu_grants(pig_b), .perf_lsu_grants(plg_b), .perf_conflicts(pc_b),
`endif
        .mem_en(men_b), .mem_addr(maddr_b), .mem_wen(mwen_b), .mem_wdata(mwdata_b),
        .mem_wmask(mwmask_b), .mem_rdata(mrdata_b)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic to_pos();
        @(posedge clk);
        #1;
    endtask

    task automatic to_neg();
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int wen_cnt, resp_at, resp_cnt, ng;
        logic [9:0] order;

        rst_n = 1'b0;
        ifu_req_valid = 1'b0; ifu_req_addr = 64'd0;
        lsu_req_valid = 1'b0; lsu_req_addr = 64'd0; lsu_req_wen = 1'b0;
        lsu_req_wdata = 64'd0; lsu_req_wmask = 8'd0;
        rd_val = 64'h1111_2222_3333_4444;

        // Reset state
        to_neg();
        chk("rst_ifu_rv", {63'd0, ifu_rv_a}, 64'd0);
        chk("rst_lsu_rv", {63'd0, lsu_rv_a}, 64'd0);
        chk("rst_mem_en", {63'd0, men_a}, 64'd0);
        chk("rst_mem_wen", {63'd0, mwen_b}, 64'd0);
        chk("rst_mem_addr", maddr_a, 64'd0);
        chk("rst_inst", {32'd0, inst_a}, 64'd0);
        to_pos();
        rst_n = 1'b1;
        to_pos();

        // IFU read, latency 1, upper lane
        ifu_req_valid = 1'b1; ifu_req_addr = 64'h8000_0004;
        to_neg();
        chk("t1_ifu_ready", {63'd0, ifu_rdy_a}, 64'd1);
        chk("t1_lsu_ready", {63'd0, lsu_rdy_a}, 64'd0);
        to_pos();
        ifu_req_valid = 1'b0;
        to_neg();
        chk("t1_wait_mem_en", {63'd0, men_a}, 64'd1);
        chk("t1_wait_addr", maddr_a, 64'h8000_0004);
        chk("t1_wait_rv", {63'd0, ifu_rv_a}, 64'd0);
        chk("t1_wait_ready", {63'd0, ifu_rdy_a}, 64'd0);
        to_pos();
        to_neg();
        chk("t1_resp_rv", {63'd0, ifu_rv_a}, 64'd1);
        chk("t1_resp_inst", {32'd0, inst_a}, 64'h1111_2222);
        to_pos();
        to_neg();
        chk("t1_after_rv", {63'd0, ifu_rv_a}, 64'd0);
        chk("t1_hold_inst", {32'd0, inst_a}, 64'h1111_2222);
        chk("t1_after_mem_en", {63'd0, men_a}, 64'd0);
        chk("t1_hold_addr", maddr_a, 64'h8000_0004);
        repeat (4) to_pos();

        // LSU store on the latency-3 instance
        lsu_req_valid = 1'b1; lsu_req_wen = 1'b1; lsu_req_addr = 64'h8000_1000;
        lsu_req_wdata = 64'hDEAD; lsu_req_wmask = 8'h03;
        to_neg();
        chk("t2_lsu_ready", {63'd0, lsu_rdy_b}, 64'd1);
        to_pos();
        lsu_req_valid = 1'b0; lsu_req_wen = 1'b0;
        wen_cnt = 0; resp_at = 0;
        for (int c = 1; c <= 6; c++) begin
            to_neg();
            if (c == 1) begin
                chk("t2_wdata", mwdata_b, 64'hDEAD);
                chk("t2_wmask", {56'd0, mwmask_b}, 64'h03);
                chk("t2_mem_en", {63'd0, men_b}, 64'd0);
            end
            if (mwen_b) wen_cnt++;
            if (lsu_rv_b) begin
                resp_at = c;
                chk("t2_rdata", lrd_b, 64'd0);
            end
            to_pos();
        end
        chk("t2_wen_cycles", 64'(wen_cnt), 64'd1);
        chk("t2_resp_latency", 64'(resp_at), 64'd4);

        // Starvation guard on the latency-1 instance
        rd_val = 64'h0123_4567_89AB_CDEF;
        ifu_req_valid = 1'b1; ifu_req_addr = 64'h8000_0000;
        lsu_req_valid = 1'b1; lsu_req_addr = 64'h8000_2000; lsu_req_wen = 1'b0;
        ng = 0; order = 10'd0;
        for (int c = 0; c < 40 && ng < 10; c++) begin
            to_neg();
            if (c == 0) begin
                chk("t3_first_ifu_ready", {63'd0, ifu_rdy_a}, 64'd0);
                chk("t3_first_lsu_ready", {63'd0, lsu_rdy_a}, 64'd1);
            end
            if (ifu_rdy_a) begin
                order[ng] = 1'b0; ng++;
            end else if (lsu_rdy_a) begin
                order[ng] = 1'b1; ng++;
            end
            to_pos();
        end
        ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
        chk("t3_grant_count", 64'(ng), 64'd10);
        chk("t3_grant_order", {54'd0, order}, 64'h1EF);
        repeat (6) to_pos();
        to_neg();
        chk("t3_inst", {32'd0, inst_a}, 64'h89AB_CDEF);
        chk("t3_lsu_rdata", lrd_a, 64'h0123_4567_89AB_CDEF);
`ifdef PMEM_ARB_PERF_EN
        chk("perf_ifu", {32'd0, pig_a}, 64'd3);
        chk("perf_lsu", {32'd0, plg_a}, 64'd9);
        chk("perf_conf", {32'd0, pc_a}, 64'd10);
`endif
        to_pos();

        // Reset during WAIT of an LSU load on the latency-3 instance
        lsu_req_valid = 1'b1; lsu_req_addr = 64'h8000_3000;
        to_neg();
        chk("t4_lsu_ready", {63'd0, lsu_rdy_b}, 64'd1);
        to_pos();
        lsu_req_valid = 1'b0;
        to_neg();
        chk("t4_wait_mem_en", {63'd0, men_b}, 64'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("t4_rst_mem_en", {63'd0, men_b}, 64'd0);
        chk("t4_rst_mem_addr", maddr_b, 64'd0);
        chk("t4_rst_rdata", lrd_b, 64'd0);
        to_pos();
        rst_n = 1'b1;
        resp_cnt = 0;
        for (int c = 0; c < 6; c++) begin
            to_neg();
            if (lsu_rv_b) resp_cnt++;
            to_pos();
        end
        chk("t4_no_resp", 64'(resp_cnt), 64'd0);

        rd_val = 64'hCAFE_BABE_0000_0001;
        lsu_req_valid = 1'b1; lsu_req_addr = 64'h8000_3008;
        to_neg();
        chk("t4_new_ready", {63'd0, lsu_rdy_b}, 64'd1);
        to_pos();
        lsu_req_valid = 1'b0;
        resp_at = 0; resp_cnt = 0;
        for (int c = 1; c <= 8; c++) begin
            to_neg();
            if (lsu_rv_b) begin
                resp_cnt++;
                resp_at = c;
            end
            to_pos();
        end
        chk("t4_new_resp_at", 64'(resp_at), 64'd4);
        chk("t4_new_resp_cnt", 64'(resp_cnt), 64'd1);
        chk("t4_new_rdata", lrd_b, 64'hCAFE_BABE_0000_0001);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
